// File: rtl/gate_vector_checker.sv
// Checks two-input gate block samples against the golden truth table.
// Optional first-failure capture: define GATE_CHK_FIRST_ERR_EN.
module gate_vector_checker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             A,
  input  logic             B,
  input  logic [5:0]       Y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [3:0]       covered,
  output logic [1:0]       first_err_ab,
  output logic [5:0]       first_err_mask
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic             smp_v_q, smp_v_d;
  logic             smp_a_q, smp_a_d;
  logic             smp_b_q, smp_b_d;
  logic [5:0]       smp_y_q, smp_y_d;
  logic [CNT_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [3:0]       cov_q, cov_d;
  logic [5:0]       gold;
  logic [5:0]       mask;
  logic [1:0]       smp_ab;

  always_comb begin
    smp_ab  = {smp_a_q, smp_b_q};
    gold    = {~(smp_a_q ^ smp_b_q),
               smp_a_q ^ smp_b_q,
               ~(smp_a_q | smp_b_q),
               ~(smp_a_q & smp_b_q),
               smp_a_q | smp_b_q,
               smp_a_q & smp_b_q};
    mask    = smp_y_q ^ gold;
    state_d = state_q;
    smp_v_d = smp_v_q;
    smp_a_d = smp_a_q;
    smp_b_d = smp_b_q;
    smp_y_d = smp_y_q;
    vec_d   = vec_q;
    err_d   = err_q;
    cov_d   = cov_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          smp_v_d = 1'b0;
          vec_d   = '0;
          err_d   = '0;
          cov_d   = '0;
        end
      end
      RUN: begin
        smp_v_d = in_valid;
        smp_a_d = A;
        smp_b_d = B;
        smp_y_d = Y;
        if (smp_v_q) begin
          if (vec_q != CNT_MAX) vec_d = vec_q + 1'b1;
          if (mask != 6'd0 && err_q != CNT_MAX)
            err_d = err_q + 1'b1;
          cov_d = cov_q | (4'b0001 << smp_ab);
          // the completing compare also drops whatever arrived with it
          if (cov_d == 4'hF) begin
            state_d = DONE;
            smp_v_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      smp_v_q <= 1'b0;
      smp_a_q <= 1'b0;
      smp_b_q <= 1'b0;
      smp_y_q <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      cov_q   <= '0;
    end else begin
      state_q <= state_d;
      smp_v_q <= smp_v_d;
      smp_a_q <= smp_a_d;
      smp_b_q <= smp_b_d;
      smp_y_q <= smp_y_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      cov_q   <= cov_d;
    end
  end

`ifdef GATE_CHK_FIRST_ERR_EN
  logic [1:0] fe_ab_q, fe_ab_d;
  logic [5:0] fe_mask_q, fe_mask_d;

  // err_q never returns to zero within a run, so it marks "seen"
  always_comb begin
    fe_ab_d   = fe_ab_q;
    fe_mask_d = fe_mask_q;
    if (state_q != RUN && start) begin
      fe_ab_d   = '0;
      fe_mask_d = '0;
    end else if (state_q == RUN && smp_v_q &&
                 mask != 6'd0 && err_q == '0) begin
      fe_ab_d   = smp_ab;
      fe_mask_d = mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fe_ab_q   <= '0;
      fe_mask_q <= '0;
    end else begin
      fe_ab_q   <= fe_ab_d;
      fe_mask_q <= fe_mask_d;
    end
  end

  assign first_err_ab   = fe_ab_q;
  assign first_err_mask = fe_mask_q;
`else
  assign first_err_ab   = 2'b00;
  assign first_err_mask = 6'b000000;
`endif

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign pass      = done && (err_q == '0);
  assign vec_count = vec_q;
  assign err_count = err_q;
  assign covered   = cov_q;

endmodule
